// File: rtl/framebuffer_write_arbiter_pkg.sv
// Shared encodings and default geometry for the framebuffer write path.
// The framebuffer and scan-out blocks use the same constants.
package framebuffer_write_arbiter_pkg;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_FILL = 1'b1;

    localparam logic [0:0] GRANT_CPU  = 1'b0;
    localparam logic [0:0] GRANT_FILL = 1'b1;

    localparam int unsigned DEFAULT_BITS_PER_PIXEL    = 4;
    localparam int unsigned DEFAULT_FRAMEBUFFER_DEPTH = 640 * 480;

endpackage

// File: rtl/framebuffer_fill_counter.sv
// Fill address / remaining-pixel counter with load and single-step.
// Pure datapath: contents only matter while the arbiter is in FILL.
module framebuffer_fill_counter (
    input  logic        i_Clock,
    input  logic        i_Load,
    input  logic        i_Step,
    input  logic [31:0] i_Base_Addr,
    input  logic [31:0] i_Count,
    output logic [31:0] o_Addr,
    output logic        o_Last
);

    logic [31:0] r_Remaining;

    always_ff @(posedge i_Clock) begin
        if (i_Load) begin
            o_Addr      <= i_Base_Addr;
            r_Remaining <= i_Count;
        end else if (i_Step) begin
            o_Addr      <= o_Addr + 32'd1;
            r_Remaining <= r_Remaining - 32'd1;
        end
    end

    assign o_Last = (r_Remaining == 32'd1);

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter sharing the framebuffer write port between CPU
// single-pixel writes and the linear fill engine.
module framebuffer_write_arbiter
    import framebuffer_write_arbiter_pkg::*;
#(
    parameter int unsigned BITS_PER_PIXEL    = DEFAULT_BITS_PER_PIXEL,
    parameter int unsigned FRAMEBUFFER_DEPTH = DEFAULT_FRAMEBUFFER_DEPTH
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Cpu_Write_Valid,
    input  logic [31:0]               i_Cpu_Write_Addr,
    input  logic [BITS_PER_PIXEL-1:0] i_Cpu_Write_Data,
    output logic                      o_Cpu_Write_Ready,
    input  logic                      i_Fill_Start,
    input  logic [31:0]               i_Fill_Base_Addr,
    input  logic [31:0]               i_Fill_Count,
    input  logic [BITS_PER_PIXEL-1:0] i_Fill_Color,
    output logic                      o_Fill_Busy,
    output logic                      o_Fill_Done,
    output logic                      o_Write_Enable,
    output logic [31:0]               o_Write_Addr,
    output logic [BITS_PER_PIXEL-1:0] o_Write_Data
);

    function automatic logic in_range(input logic [31:0] addr);
        return addr < FRAMEBUFFER_DEPTH;
    endfunction

    logic [0:0]                r_State;
    logic [0:0]                r_Last_Grant;
    logic [BITS_PER_PIXEL-1:0] r_Fill_Color;

    logic                      cpu_accept;
    logic                      fill_slot;
    logic                      fill_load;
    logic                      fill_empty;
    logic [31:0]               fill_addr;
    logic                      fill_last;

    logic                      wr_en_p0;
    logic [31:0]               wr_addr_p0;
    logic [BITS_PER_PIXEL-1:0] wr_data_p0;
    logic                      done_p0;

    logic                      wr_en_p1;
    logic [31:0]               wr_addr_p1;
    logic [BITS_PER_PIXEL-1:0] wr_data_p1;
    logic                      done_p1;
    logic                      busy_p1;

    framebuffer_fill_counter u_fill_counter (
        .i_Clock     (i_Clock),
        .i_Load      (fill_load),
        .i_Step      (fill_slot),
        .i_Base_Addr (i_Fill_Base_Addr),
        .i_Count     (i_Fill_Count),
        .o_Addr      (fill_addr),
        .o_Last      (fill_last)
    );

    // CPU is only blocked when a fill is running and the CPU owned the last slot.
    assign o_Cpu_Write_Ready = (r_State == STATE_IDLE) || (r_Last_Grant == GRANT_FILL);

    // Stage p0: slot decision and write selection
    always_comb begin
        cpu_accept = i_Cpu_Write_Valid && o_Cpu_Write_Ready;
        fill_slot  = (r_State == STATE_FILL) && !cpu_accept;
        fill_load  = (r_State == STATE_IDLE) && i_Fill_Start && (i_Fill_Count != 32'd0);
        fill_empty = (r_State == STATE_IDLE) && i_Fill_Start && (i_Fill_Count == 32'd0);

        wr_en_p0   = 1'b0;
        wr_addr_p0 = wr_addr_p1;
        wr_data_p0 = wr_data_p1;
        if (cpu_accept) begin
            if (in_range(i_Cpu_Write_Addr)) begin
                wr_en_p0   = 1'b1;
                wr_addr_p0 = i_Cpu_Write_Addr;
                wr_data_p0 = i_Cpu_Write_Data;
            end
        end else if (fill_slot) begin
            if (in_range(fill_addr)) begin
                wr_en_p0   = 1'b1;
                wr_addr_p0 = fill_addr;
                wr_data_p0 = r_Fill_Color;
            end
        end

        done_p0 = fill_empty || (fill_slot && fill_last);
    end

    // Stage p1: registered framebuffer port and control state
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State      <= STATE_IDLE;
            r_Last_Grant <= GRANT_FILL;
            wr_en_p1     <= 1'b0;
            wr_addr_p1   <= '0;
            wr_data_p1   <= '0;
            done_p1      <= 1'b0;
            busy_p1      <= 1'b0;
        end else begin
            wr_en_p1   <= wr_en_p0;
            wr_addr_p1 <= wr_addr_p0;
            wr_data_p1 <= wr_data_p0;
            done_p1    <= done_p0;

            if (cpu_accept || fill_load) begin
                r_Last_Grant <= GRANT_CPU;
            end else if (fill_slot) begin
                r_Last_Grant <= GRANT_FILL;
            end

            if (fill_load) begin
                r_State <= STATE_FILL;
                busy_p1 <= 1'b1;
            end else if (fill_slot && fill_last) begin
                r_State <= STATE_IDLE;
                busy_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (fill_load) begin
            r_Fill_Color <= i_Fill_Color;
        end
    end

    assign o_Write_Enable = wr_en_p1;
    assign o_Write_Addr   = wr_addr_p1;
    assign o_Write_Data   = wr_data_p1;
    assign o_Fill_Done    = done_p1;
    assign o_Fill_Busy    = busy_p1;

endmodule
